// File: rtl/riva_pkg.sv
// Shared core-wide types.
package riva_pkg;

  localparam int unsigned VidW = 5;

  typedef logic [VidW-1:0] vid_t;

endpackage

// File: rtl/vlsu_pkg.sv
// VLSU types: tracker entries and AXI
// response codes.
package vlsu_pkg;

  import riva_pkg::*;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Wide enough for any supported TxnCntW.
  localparam int unsigned TrkCntW = 16;

  typedef logic [TrkCntW-1:0] trk_cnt_t;

  typedef struct packed {
    vid_t     id;
    trk_cnt_t cnt;
    logic     err;
  } trk_entry_t;

  function automatic logic resp_is_err(
    input logic [1:0] r
  );
    return r >= AXI_RESP_SLVERR;
  endfunction

endpackage

// File: rtl/vlsu_resp_trk_queue.sv
// In-order tracking FIFO for one response
// channel (loads or stores).
module vlsu_resp_trk_queue
  import riva_pkg::*;
  import vlsu_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  vid_t            push_id_i,
  input  logic [CntW-1:0] push_cnt_i,
  input  logic            evt_i,
  input  logic            dec_i,
  input  logic            err_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            done_o,
  output vid_t            head_id_o,
  output logic            head_err_o,
  output logic            unexp_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] OccOne =
    (PtrW+1)'(1);
  localparam logic [PtrW:0] OccFull =
    (PtrW+1)'(Depth);

  trk_entry_t      ent_q [Depth];
  logic [PtrW-1:0] rd_q;
  logic [PtrW-1:0] wr_q;
  logic [PtrW:0]   occ_q;

  logic            empty;
  logic            head_done;
  logic [PtrW-1:0] nxt;
  logic [PtrW-1:0] tgt;
  logic            tgt_ok;

  assign empty     = occ_q == '0;
  assign head_done = !empty &&
                     ent_q[rd_q].cnt == '0;
  assign nxt       = rd_q + PtrW'(1);

  // A done head only waits to be popped;
  // later responses belong to the next entry.
  always_comb begin
    tgt    = rd_q;
    tgt_ok = 1'b0;
    if (!empty && !head_done) begin
      tgt_ok = 1'b1;
    end else if (head_done &&
                 occ_q > OccOne &&
                 ent_q[nxt].cnt != '0) begin
      tgt    = nxt;
      tgt_ok = 1'b1;
    end
  end

  assign full_o     = occ_q == OccFull;
  assign done_o     = head_done;
  assign head_id_o  = ent_q[rd_q].id;
  assign head_err_o = ent_q[rd_q].err;
  assign unexp_o    = evt_i && !tgt_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        ent_q[wr_q].id  <= push_id_i;
        ent_q[wr_q].cnt <= trk_cnt_t'(push_cnt_i);
        ent_q[wr_q].err <= 1'b0;
        wr_q <= wr_q + PtrW'(1);
      end
      if (evt_i && tgt_ok) begin
        if (dec_i) begin
          ent_q[tgt].cnt <=
            ent_q[tgt].cnt - trk_cnt_t'(1);
        end
        if (err_i) begin
          ent_q[tgt].err <= 1'b1;
        end
      end
      if (pop_i) begin
        rd_q <= rd_q + PtrW'(1);
      end
      if (push_i && !pop_i) begin
        occ_q <= occ_q + OccOne;
      end else if (pop_i && !push_i) begin
        occ_q <= occ_q - OccOne;
      end
    end
  end

endmodule

// File: rtl/vlsu_resp_tracker.sv
// Tracks outstanding VLSU instructions and
// reports completion once all AXI txns return.
module vlsu_resp_tracker
  import riva_pkg::*;
  import vlsu_pkg::*;
#(
  parameter int unsigned TrkDepth = 4,
  parameter int unsigned TxnCntW  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  vid_t               issue_reqId_i,
  input  logic               issue_isLoad_i,
  input  logic [TxnCntW-1:0] issue_txnNum_i,
  input  logic               r_fire_i,
  input  logic               r_last_i,
  input  logic [1:0]         r_resp_i,
  input  logic               b_fire_i,
  input  logic [1:0]         b_resp_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output vid_t               resp_reqId_o,
  output logic               resp_isLoad_o,
  output logic               resp_err_o,
  output logic               unexp_o
);

  logic ld_full, st_full;
  logic ld_done, st_done;
  logic ld_err, st_err;
  logic ld_unexp, st_unexp;
  vid_t ld_id, st_id;
  logic ld_push, st_push;
  logic ld_pop, st_pop;
  logic sel_ld, fire;

  logic lock_q, lock_ld_q;
  logic last_ld_q, unexp_q;

  assign issue_ready_o = issue_isLoad_i ?
                         !ld_full : !st_full;
  assign ld_push = issue_valid_i &&
                   issue_ready_o &&
                   issue_isLoad_i;
  assign st_push = issue_valid_i &&
                   issue_ready_o &&
                   !issue_isLoad_i;

  vlsu_resp_trk_queue #(
    .Depth (TrkDepth),
    .CntW  (TxnCntW)
  ) u_ld_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (ld_push),
    .push_id_i  (issue_reqId_i),
    .push_cnt_i (issue_txnNum_i),
    .evt_i      (r_fire_i),
    .dec_i      (r_fire_i && r_last_i),
    .err_i      (resp_is_err(r_resp_i)),
    .pop_i      (ld_pop),
    .full_o     (ld_full),
    .done_o     (ld_done),
    .head_id_o  (ld_id),
    .head_err_o (ld_err),
    .unexp_o    (ld_unexp)
  );

  vlsu_resp_trk_queue #(
    .Depth (TrkDepth),
    .CntW  (TxnCntW)
  ) u_st_q (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (st_push),
    .push_id_i  (issue_reqId_i),
    .push_cnt_i (issue_txnNum_i),
    .evt_i      (b_fire_i),
    .dec_i      (b_fire_i),
    .err_i      (resp_is_err(b_resp_i)),
    .pop_i      (st_pop),
    .full_o     (st_full),
    .done_o     (st_done),
    .head_id_o  (st_id),
    .head_err_o (st_err),
    .unexp_o    (st_unexp)
  );

  // A stalled grant is locked so the offer
  // cannot switch queues before it is taken.
  always_comb begin
    sel_ld = lock_q ? lock_ld_q :
             (ld_done &&
              (!st_done || !last_ld_q));
    resp_valid_o  = lock_q || ld_done ||
                    st_done;
    resp_reqId_o  = '0;
    resp_isLoad_o = 1'b0;
    resp_err_o    = 1'b0;
    if (resp_valid_o) begin
      resp_reqId_o  = sel_ld ? ld_id : st_id;
      resp_isLoad_o = sel_ld;
      resp_err_o    = sel_ld ? ld_err : st_err;
    end
  end

  assign fire    = resp_valid_o && resp_ready_i;
  assign ld_pop  = fire && sel_ld;
  assign st_pop  = fire && !sel_ld;
  assign unexp_o = unexp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_ld_q <= 1'b0;
      last_ld_q <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      if (ld_unexp || st_unexp) begin
        unexp_q <= 1'b1;
      end
      if (fire) begin
        last_ld_q <= sel_ld;
        lock_q    <= 1'b0;
      end else if (resp_valid_o) begin
        lock_q    <= 1'b1;
        lock_ld_q <= sel_ld;
      end
    end
  end

endmodule

// File: tb/tb_vlsu_resp_tracker.sv
// Self-checking bench for vlsu_resp_tracker.
module tb_vlsu_resp_tracker;
  import riva_pkg::*;
  import vlsu_pkg::*;

  localparam int TXN_W = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             issue_valid_i;
  logic             issue_ready_o;
  vid_t             issue_reqId_i;
  logic             issue_isLoad_i;
  logic [TXN_W-1:0] issue_txnNum_i;
  logic             r_fire_i, r_last_i;
  logic [1:0]       r_resp_i;
  logic             b_fire_i;
  logic [1:0]       b_resp_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  vid_t             resp_reqId_o;
  logic             resp_isLoad_o;
  logic             resp_err_o;
  logic             unexp_o;

  vlsu_resp_tracker #(
    .TrkDepth (4),
    .TxnCntW  (TXN_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_reqId_i  (issue_reqId_i),
    .issue_isLoad_i (issue_isLoad_i),
    .issue_txnNum_i (issue_txnNum_i),
    .r_fire_i       (r_fire_i),
    .r_last_i       (r_last_i),
    .r_resp_i       (r_resp_i),
    .b_fire_i       (b_fire_i),
    .b_resp_i       (b_resp_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_reqId_o   (resp_reqId_o),
    .resp_isLoad_o  (resp_isLoad_o),
    .resp_err_o     (resp_err_o),
    .unexp_o        (unexp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    vid_t       id;
    int         txn;
    int         beats;
    int         err_beat;
    logic [1:0] code;
    logic       exp_err;
  } vec_t;

  typedef struct {
    vid_t id;
    logic ld;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t e0, e1;
  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tb_last_ld = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rsp();
    r_fire_i = 1'b0;
    r_last_i = 1'b0;
    r_resp_i = AXI_RESP_OKAY;
    b_fire_i = 1'b0;
    b_resp_i = AXI_RESP_OKAY;
  endtask

  task automatic drv_rsp(input logic ld,
                         input logic last,
                         input logic [1:0] code);
    if (ld) begin
      r_fire_i = 1'b1;
      r_last_i = last;
      r_resp_i = code;
    end else begin
      b_fire_i = 1'b1;
      b_resp_i = code;
    end
  endtask

  task automatic rsp(input logic ld,
                     input logic [1:0] code);
    drv_rsp(ld, 1'b1, code);
    tick();
    clr_rsp();
  endtask

  task automatic issue(input logic ld,
                       input vid_t id,
                       input int txn);
    issue_valid_i  = 1'b1;
    issue_isLoad_i = ld;
    issue_reqId_i  = id;
    issue_txnNum_i = txn[TXN_W-1:0];
    #3 chk("issue_ready", issue_ready_o, 1);
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic push_exp(input vid_t id,
                          input logic ld,
                          input logic err);
    exp_t e;
    e.id  = id;
    e.ld  = ld;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0;
         i < 20 && exp_q.size() != 0; i++)
      tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tb_last_ld = 1'b0;
  endtask

  // Completion scoreboard.
  always @(negedge clk) begin
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_resp: got id %0d want none",
                 resp_reqId_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", resp_reqId_o, mon_e.id);
        chk("resp_isLoad", resp_isLoad_o, mon_e.ld);
        chk("resp_err", resp_err_o, mon_e.err);
        tb_last_ld = mon_e.ld;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 5'd3, 2, 1, -1,
                AXI_RESP_OKAY, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 1, 4, 2,
                AXI_RESP_SLVERR, 1'b1};
    vecs[2] = '{1'b1, 5'd7, 3, 2, -1,
                AXI_RESP_OKAY, 1'b0};
    vecs[3] = '{1'b0, 5'd9, 1, 1, 0,
                AXI_RESP_DECERR, 1'b1};
    vecs[4] = '{1'b1, 5'd31, 1, 1, 0,
                AXI_RESP_DECERR, 1'b1};
    vecs[5] = '{1'b0, 5'd0, 4, 1, 1,
                AXI_RESP_EXOKAY, 1'b0};

    issue_valid_i  = 1'b0;
    issue_reqId_i  = '0;
    issue_isLoad_i = 1'b0;
    issue_txnNum_i = '0;
    resp_ready_i   = 1'b1;
    clr_rsp();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;

    #3;
    chk("rst_valid", resp_valid_o, 0);
    chk("rst_id", resp_reqId_o, 0);
    chk("rst_isLoad", resp_isLoad_o, 0);
    chk("rst_err", resp_err_o, 0);
    chk("rst_unexp", unexp_o, 0);
    chk("rst_ready_st", issue_ready_o, 1);
    issue_isLoad_i = 1'b1;
    #1 chk("rst_ready_ld", issue_ready_o, 1);
    tick();

    // Single-instruction vectors.
    foreach (vecs[v]) begin
      int n;
      n = vecs[v].txn * vecs[v].beats;
      issue(vecs[v].ld, vecs[v].id, vecs[v].txn);
      for (int b = 0; b < n; b++) begin
        logic last;
        last = (b % vecs[v].beats) ==
               vecs[v].beats - 1;
        if (b == n - 1)
          push_exp(vecs[v].id, vecs[v].ld,
                   vecs[v].exp_err);
        drv_rsp(vecs[v].ld, last,
                (b == vecs[v].err_beat) ?
                vecs[v].code : AXI_RESP_OKAY);
        #3 chk("no_early_valid", resp_valid_o, 0);
        tick();
        clr_rsp();
      end
      #3 chk("latency1_valid", resp_valid_o, 1);
      tick();
      #3 chk("popped_valid", resp_valid_o, 0);
      chk("vec_drained", exp_q.size(), 0);
      tick();
    end

    // Simultaneous load/store completion.
    issue(1'b1, 5'd10, 1);
    issue(1'b0, 5'd11, 1);
    e0 = '{tb_last_ld ? 5'd11 : 5'd10,
           !tb_last_ld, 1'b0};
    e1 = '{tb_last_ld ? 5'd10 : 5'd11,
           tb_last_ld, 1'b0};
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    drv_rsp(1'b1, 1'b1, AXI_RESP_OKAY);
    drv_rsp(1'b0, 1'b1, AXI_RESP_OKAY);
    #3 chk("tie_pre_valid", resp_valid_o, 0);
    tick();
    clr_rsp();
    #3 chk("tie_v1", resp_valid_o, 1);
    chk("tie_ld1", resp_isLoad_o, e0.ld);
    tick();
    #3 chk("tie_v2", resp_valid_o, 1);
    chk("tie_ld2", resp_isLoad_o, e1.ld);
    tick();
    #3 chk("tie_v3", resp_valid_o, 0);

    // Same, but consumer stalls 3 cycles.
    issue(1'b1, 5'd12, 1);
    issue(1'b0, 5'd13, 1);
    e0 = '{tb_last_ld ? 5'd13 : 5'd12,
           !tb_last_ld, 1'b0};
    e1 = '{tb_last_ld ? 5'd12 : 5'd13,
           tb_last_ld, 1'b0};
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    resp_ready_i = 1'b0;
    drv_rsp(1'b1, 1'b1, AXI_RESP_OKAY);
    drv_rsp(1'b0, 1'b1, AXI_RESP_OKAY);
    tick();
    clr_rsp();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_valid", resp_valid_o, 1);
      chk("stall_id", resp_reqId_o, e0.id);
      chk("stall_ld", resp_isLoad_o, e0.ld);
      chk("stall_err", resp_err_o, 0);
      tick();
    end
    resp_ready_i = 1'b1;
    wait_drain();

    // Fill the store queue.
    for (int i = 0; i < 4; i++)
      issue(1'b0, vid_t'(20 + i), 1);
    issue_valid_i  = 1'b1;
    issue_isLoad_i = 1'b0;
    issue_reqId_i  = 5'd25;
    issue_txnNum_i = 8'd1;
    #3 chk("st_full_ready", issue_ready_o, 0);
    issue_isLoad_i = 1'b1;
    issue_reqId_i  = 5'd24;
    #1 chk("ld_ready_st_full", issue_ready_o, 1);
    tick();
    issue_valid_i  = 1'b0;
    issue_isLoad_i = 1'b0;
    push_exp(5'd20, 1'b0, 1'b0);
    rsp(1'b0, AXI_RESP_OKAY);
    #3 chk("st_ready_at_pop", issue_ready_o, 0);
    tick();
    #3 chk("st_ready_after_pop", issue_ready_o, 1);
    for (int i = 1; i < 4; i++) begin
      push_exp(vid_t'(20 + i), 1'b0, 1'b0);
      rsp(1'b0, AXI_RESP_OKAY);
    end
    push_exp(5'd24, 1'b1, 1'b0);
    rsp(1'b1, AXI_RESP_OKAY);
    wait_drain();

    // Response with nothing outstanding.
    #3 chk("unexp_pre", unexp_o, 0);
    rsp(1'b0, AXI_RESP_OKAY);
    #3 chk("unexp_set", unexp_o, 1);
    chk("unexp_no_resp", resp_valid_o, 0);
    tick();
    tick();
    #3 chk("unexp_sticky", unexp_o, 1);
    do_reset();
    #3 chk("unexp_rst_clr", unexp_o, 0);

    // Response racing enqueue to empty queue.
    issue_valid_i  = 1'b1;
    issue_isLoad_i = 1'b0;
    issue_reqId_i  = 5'd14;
    issue_txnNum_i = 8'd1;
    drv_rsp(1'b0, 1'b1, AXI_RESP_SLVERR);
    tick();
    issue_valid_i = 1'b0;
    clr_rsp();
    #3 chk("race_unexp", unexp_o, 1);
    chk("race_no_valid", resp_valid_o, 0);
    tick();
    #3 chk("race_still_pend", resp_valid_o, 0);
    push_exp(5'd14, 1'b0, 1'b0);
    rsp(1'b0, AXI_RESP_OKAY);
    wait_drain();
    do_reset();

    // Reset with work outstanding.
    issue(1'b1, 5'd1, 2);
    issue(1'b0, 5'd2, 2);
    drv_rsp(1'b1, 1'b1, AXI_RESP_OKAY);
    drv_rsp(1'b0, 1'b1, AXI_RESP_SLVERR);
    tick();
    clr_rsp();
    do_reset();
    #3;
    chk("mrst_valid", resp_valid_o, 0);
    chk("mrst_id", resp_reqId_o, 0);
    chk("mrst_isLoad", resp_isLoad_o, 0);
    chk("mrst_err", resp_err_o, 0);
    chk("mrst_unexp", unexp_o, 0);
    chk("mrst_ready", issue_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #3 chk("mrst_quiet", resp_valid_o, 0);
    end
    tick();
    rsp(1'b0, AXI_RESP_OKAY);
    #3 chk("mrst_discarded", unexp_o, 1);
    chk("mrst_no_resp", resp_valid_o, 0);
    tick();

    chk("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
